// File: rtl/oled_pkg.sv
// Shared types and constants for the OLED SPI byte writer.
package oled_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    DONE
  } oled_spi_state_t;

  localparam int OLED_DATA_W        = 10;
  localparam int OLED_DATA_DC_BIT   = 8;
  localparam int OLED_DATA_HOLD_BIT = 9;

endpackage

// File: rtl/oled_spi_write_if.sv
// Write-request handshake between a host and the OLED SPI byte writer.
interface oled_spi_write_if;
  import oled_pkg::*;

  logic                   WRITE_START;
  logic [OLED_DATA_W-1:0] DATA;
  logic                   WRITE_DONE;
  logic                   BUSY;

  modport master (output WRITE_START, DATA, input WRITE_DONE, BUSY);
  modport slave  (input WRITE_START, DATA, output WRITE_DONE, BUSY);
endinterface

// File: rtl/oled_spi_tick.sv
// Shared divider: one-cycle tick every CLK_DIV cycles while enabled, realigned by restart.
module oled_spi_tick #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic CLK,
  input  logic RST,
  input  logic en,
  input  logic restart,
  output logic tick
);
  localparam int unsigned      CNT_W    = $clog2(CLK_DIV + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // NOTE: every variable written here gets a default first, so no latch can be inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (restart) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  // NOTE: state flops use non-blocking assignments so all flops update together.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign tick = en && (cnt_q == CNT_LAST);
endmodule

// File: rtl/oled_spi_write.sv
// SPI mode-0 byte writer for an OLED controller (CS, D/C, SCLK, SDIN).
// Optional OLED_SPI_CS_HOLD_EN: DATA[9]=1 keeps CS low after the byte completes.
module oled_spi_write
  import oled_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic            CLK,
  input  logic            RST,
  oled_spi_write_if.slave wr,
  output logic            OLED_SCLK,
  output logic            OLED_SDIN,
  output logic            OLED_CS,
  output logic            OLED_DC
);
  oled_spi_state_t state_q, state_d;
  logic [7:0] data_q, data_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic       phase_q, phase_d;
  logic       dc_q, dc_d;
  logic       cs_low_q, cs_low_d;
  logic       accept, tick, cs_keep;

  oled_spi_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .CLK    (CLK),
    .RST    (RST),
    .en     (state_q != IDLE),
    .restart(accept),
    .tick   (tick)
  );

`ifdef OLED_SPI_CS_HOLD_EN
  logic hold_q, hold_d;
  assign hold_d  = accept ? wr.DATA[OLED_DATA_HOLD_BIT] : hold_q;
  assign cs_keep = hold_q;
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) hold_q <= 1'b0;
    else     hold_q <= hold_d;
  end
`else
  logic unused_hold;
  assign unused_hold = wr.DATA[OLED_DATA_HOLD_BIT];
  assign cs_keep     = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    bit_cnt_d = bit_cnt_q;
    phase_d   = phase_q;
    dc_d      = dc_q;
    cs_low_d  = cs_low_q;
    accept    = 1'b0;
    unique case (state_q)
      IDLE: if (wr.WRITE_START) begin
        accept    = 1'b1;
        state_d   = SETUP;
        data_d    = wr.DATA[7:0];
        dc_d      = wr.DATA[OLED_DATA_DC_BIT];
        cs_low_d  = 1'b1;
        bit_cnt_d = 3'd7;
        phase_d   = 1'b0;
      end
      SETUP: if (tick) state_d = SHIFT;
      // phase_q=0 is the SCLK-low half of a bit; the bit index moves on the falling edge.
      SHIFT: if (tick) begin
        phase_d = ~phase_q;
        if (phase_q) begin
          if (bit_cnt_q == 3'd0) state_d = HOLD;
          else                   bit_cnt_d = bit_cnt_q - 3'd1;
        end
      end
      HOLD: if (tick) begin
        state_d  = DONE;
        cs_low_d = cs_keep;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= IDLE;
      data_q    <= '0;
      bit_cnt_q <= '0;
      phase_q   <= 1'b0;
      dc_q      <= 1'b0;
      cs_low_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      bit_cnt_q <= bit_cnt_d;
      phase_q   <= phase_d;
      dc_q      <= dc_d;
      cs_low_q  <= cs_low_d;
    end
  end

  // Outputs decode directly from flops, so an asynchronous reset reaches the pins at once.
  assign OLED_SCLK     = (state_q == SHIFT) && phase_q;
  assign OLED_SDIN     = (state_q == SETUP || state_q == SHIFT) ? data_q[bit_cnt_q] : 1'b0;
  assign OLED_CS       = ~cs_low_q;
  assign OLED_DC       = dc_q;
  assign wr.WRITE_DONE = (state_q == DONE);
  assign wr.BUSY       = (state_q != IDLE);
endmodule

// File: tb/tb_oled_spi_write.sv
// Self-checking bench: random bytes on CLK_DIV=4 and CLK_DIV=1 writers against a timing model.
module tb_oled_spi_write;
  import oled_pkg::*;

`ifdef OLED_SPI_CS_HOLD_EN
  localparam bit HOLD_EN = 1'b1;
`else
  localparam bit HOLD_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  oled_spi_write_if if4 ();
  oled_spi_write_if if1 ();
  logic sclk4, sdin4, cs4, dc4, sclk1, sdin1, cs1, dc1;

  oled_spi_write #(.CLK_DIV(4)) dut4 (
    .CLK(clk), .RST(rst), .wr(if4),
    .OLED_SCLK(sclk4), .OLED_SDIN(sdin4), .OLED_CS(cs4), .OLED_DC(dc4)
  );
  oled_spi_write #(.CLK_DIV(1)) dut1 (
    .CLK(clk), .RST(rst), .wr(if1),
    .OLED_SCLK(sclk1), .OLED_SDIN(sdin1), .OLED_CS(cs1), .OLED_DC(dc1)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int done4 = 0;
  int done1 = 0;
  int first_busy_cyc = 0;
  bit sel = 1'b0;            // 0: CLK_DIV=4 writer, 1: CLK_DIV=1 writer
  bit cs_held [2] = '{1'b0, 1'b0};

  // {sclk, sdin, cs, dc, done, busy} of the selected writer
  logic [5:0] obs;
  always_comb obs = sel ? {sclk1, sdin1, cs1, dc1, if1.WRITE_DONE, if1.BUSY}
                        : {sclk4, sdin4, cs4, dc4, if4.WRITE_DONE, if4.BUSY};

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (if4.WRITE_DONE === 1'b1) done4 <= done4 + 1;
    if (if1.WRITE_DONE === 1'b1) done1 <= done1 + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s @cyc %0d sel %0d: got %h expected %h", tag, cyc, sel, got, exp);
    end
  endtask

  task automatic drive(input logic start, input logic [9:0] data);
    if (sel) begin if1.WRITE_START = start; if1.DATA = data; end
    else     begin if4.WRITE_START = start; if4.DATA = data; end
  endtask

  // Expected pins n cycles after the accept cycle, straight from the byte timeline.
  function automatic logic [5:0] model(input int d, input logic [9:0] data, input int n,
                                       input bit held_before, output logic [5:0] mask);
    logic [5:0] e;
    int k;
    bit keep;
    keep = HOLD_EN && data[9];
    e    = '0;
    mask = 6'b111111;
    if (n == 0) begin
      e[3] = !held_before; mask[4] = 1'b0; mask[2] = 1'b0;
    end else if (n <= d) begin
      e[4] = data[7]; e[2] = data[8]; e[0] = 1'b1;
    end else if (n <= 17 * d) begin
      k = n - d - 1;
      e[5] = ((k / d) % 2) == 1;
      e[4] = data[7 - k / (2 * d)];
      e[2] = data[8]; e[0] = 1'b1;
    end else if (n <= 18 * d) begin
      mask[4] = 1'b0; e[2] = data[8]; e[0] = 1'b1;
    end else begin
      mask[4] = 1'b0; e[3] = !keep; e[2] = data[8]; e[1] = 1'b1; e[0] = 1'b1;
    end
    return e;
  endfunction

  // Entered and left at posedge+1 with the writer in IDLE; abort_n>0 resets mid-byte.
  task automatic send_byte(input logic [9:0] data, input int d, input bit keep, input int abort_n);
    logic [5:0] e, m;
    logic [7:0] bits;
    int nbits, done_at;
    logic prev_sclk;
    bits = '0; nbits = 0; done_at = -1; prev_sclk = 1'b0;
    drive(1'b1, data);
    for (int n = 0; n <= 18 * d + 1; n++) begin
      if (n > 0) begin
        @(posedge clk); #1;
        drive(keep ? 1'b1 : 1'($urandom_range(1, 0)), 10'($urandom));
      end
      @(negedge clk);
      if (n == 1) first_busy_cyc = cyc;
      e = model(d, data, n, cs_held[sel], m);
      check("pins", {26'd0, obs & m}, {26'd0, e & m});
      if (obs[5] === 1'b1 && prev_sclk === 1'b0) begin
        bits = {bits[6:0], obs[4]};
        nbits++;
      end
      prev_sclk = obs[5];
      if (obs[1] === 1'b1 && done_at < 0) done_at = n;
      if (n == abort_n) begin
        #1 rst = 1'b1;
        #1 check("rst_pins", {26'd0, obs}, 32'h08);
        cs_held[0] = 1'b0;
        cs_held[1] = 1'b0;
        return;
      end
    end
    check("rise_bits", {24'd0, bits}, {24'd0, data[7:0]});
    check("rise_cnt", nbits, 8);
    check("done_lat", done_at, 18 * d + 1);
    check("cs_at_done", {31'd0, obs[3]}, {31'd0, !(HOLD_EN && data[9])});
    cs_held[sel] = HOLD_EN && data[9];
    @(posedge clk); #1;
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      drive(1'b0, 10'($urandom));
      @(negedge clk);
      check("idle", {29'd0, obs[5], obs[3], obs[0]}, {29'd0, 1'b0, !cs_held[sel], 1'b0});
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int t0, t1, t2, dc_before;
    logic [9:0] rd;
    rst = 1'b1;
    if4.WRITE_START = 1'b0; if4.DATA = '0;
    if1.WRITE_START = 1'b0; if1.DATA = '0;
    #1;
    sel = 1'b0; #0 check("reset4", {26'd0, obs}, 32'h08);
    sel = 1'b1; #0 check("reset1", {26'd0, obs}, 32'h08);
    sel = 1'b0;
    @(posedge clk); #1 rst = 1'b0;

    // Accept on the very first edge after release, then the directed bytes.
    send_byte(10'h0AE, 4, 1'b0, -1);
    idle(3);
    send_byte(10'h1FF, 4, 1'b0, -1);
    idle(2);
    send_byte(10'h100, 4, 1'b0, -1);

    for (int i = 0; i < 6; i++) begin
      idle($urandom_range(3, 0));
      send_byte(10'($urandom), 4, 1'b0, -1);
    end

    // WRITE_START held high across three bytes.
    idle(2);
    dc_before = done4;
    send_byte(10'($urandom), 4, 1'b1, -1); t0 = first_busy_cyc;
    send_byte(10'($urandom), 4, 1'b1, -1); t1 = first_busy_cyc;
    send_byte(10'($urandom), 4, 1'b1, -1); t2 = first_busy_cyc;
    idle(3);
    check("spacing01", t1 - t0, 74);
    check("spacing12", t2 - t1, 74);
    check("held_dones", done4 - dc_before, 3);

    // CS hold across two bytes.
    idle(1);
    send_byte(10'h2A5, 4, 1'b0, -1);
    drive(1'b0, '0);
    @(negedge clk);
    check("cs_between", {31'd0, obs[3]}, {31'd0, !HOLD_EN});
    @(posedge clk); #1;
    idle(2);
    send_byte(10'h0A5, 4, 1'b0, -1);
    idle(2);
    check("cs_after", {31'd0, obs[3]}, 32'd1);

    // Reset at +30 of a byte: no DONE, then a normal byte.
    dc_before = done4;
    rd = 10'($urandom);
    send_byte(rd, 4, 1'b0, 30);
    drive(1'b0, '0);
    @(posedge clk); #1;
    check("rst_held", {26'd0, obs}, 32'h08);
    rst = 1'b0;
    idle(80);
    check("no_done", done4 - dc_before, 0);
    send_byte(10'($urandom), 4, 1'b0, -1);
    idle(1);

    // CLK_DIV=1 writer.
    sel = 1'b1;
    send_byte(10'h081, 1, 1'b0, -1);
    for (int i = 0; i < 5; i++) begin
      idle($urandom_range(2, 0));
      send_byte(10'($urandom), 1, 1'b0, -1);
    end
    idle(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/oled_spi_write.md
OLED_SPI_WRITE -- requirements
Module: oled_spi_write

Interface
REQ-001 Parameter CLK_DIV, default 4: SCLK half-period in CLK cycles; legal range 1..255.
REQ-002 CLK  input  1  system clock; every flop rises on CLK.
REQ-003 RST  input  1  reset; one clock; reset is asynchronous and active-high.
REQ-004 WRITE_START  input  1  write request; sampled only in IDLE.
REQ-005 DATA  input  10  [7:0] byte; [8] D/C (1=data, 0=command); [9] CS hold.
REQ-006 WRITE_DONE  output  1  one-cycle pulse at end of byte.
REQ-007 BUSY  output  1  high from the cycle after accept through the DONE cycle.
REQ-008 OLED_SCLK  output  1  SPI clock, mode 0, idles low.
REQ-009 OLED_SDIN  output  1  serial data, MSB first.
REQ-010 OLED_CS  output  1  chip select, active-low.
REQ-011 OLED_DC  output  1  data/command select.

Function
REQ-012 The FSM SHALL have the states IDLE, SETUP, SHIFT, HOLD and DONE.
REQ-013 IDLE: WRITE_START=1 latches DATA; the FSM moves to SETUP on the next cycle.
- DATA changes after the accept cycle have no effect on the byte in flight.
REQ-014 SETUP lasts CLK_DIV cycles.
- OLED_CS=0 throughout.
- OLED_DC = latched DATA[8], updated only on entry to SETUP.
- OLED_SDIN = bit 7.
REQ-015 SHIFT covers 8 bits, each 2*CLK_DIV cycles.
- Each bit: SCLK low for CLK_DIV cycles, then high for CLK_DIV cycles.
- SDIN changes only on SCLK falling transitions, to the next bit.
REQ-016 HOLD lasts CLK_DIV cycles with SCLK=0 and CS=0; CS then deasserts as in REQ-019.
REQ-017 DONE lasts 1 cycle with WRITE_DONE=1; the FSM then returns to IDLE.
REQ-018 WRITE_DONE SHALL assert exactly 18*CLK_DIV+1 cycles after the accept cycle.
REQ-019 CS release: OLED_CS returns to 1 on entry to DONE, except as in REQ-029.
REQ-020 While BUSY=1, WRITE_START is ignored, including during the DONE cycle.
- If WRITE_START is held high, the next accept occurs in the IDLE cycle after DONE.
REQ-021 A single divider counter, $clog2(CLK_DIV+1) bits wide, SHALL wrap at CLK_DIV-1.
- A 3-bit counter tracks bits 7..0.
REQ-022 CLK_DIV=1: SCLK toggles every CLK cycle and the latency is 19 cycles.

Reset
REQ-023 RST=1 SHALL force the outputs immediately, without waiting for a clock edge.
- OLED_SCLK=0, OLED_SDIN=0, OLED_CS=1, OLED_DC=0, WRITE_DONE=0, BUSY=0.
- FSM goes to IDLE.
REQ-024 Reset mid-byte SHALL abort the transfer without producing a WRITE_DONE pulse.
REQ-025 The first accept after reset release SHALL be possible on the first CLK edge with RST=0.

Configuration
REQ-026 Macro OLED_SPI_CS_HOLD_EN SHALL select CS-hold support.
REQ-027 Defined: latched DATA[9]=1 keeps OLED_CS=0 through DONE and the following IDLE.
- CS stays low until a byte with DATA[9]=0 completes, or reset.
- SETUP still lasts CLK_DIV cycles.
REQ-028 Undefined: DATA[9] is ignored and CS deasserts after every byte.
REQ-029 REQ-019 is overridden only by REQ-027.

Structure
REQ-030 The shared package oled_pkg SHALL hold the following.
- State enum oled_spi_state_t.
- DATA field positions OLED_DATA_DC_BIT=8 and OLED_DATA_HOLD_BIT=9.
REQ-031 One sub-module, oled_spi_tick, SHALL provide the divider and emit a one-cycle tick every CLK_DIV cycles.
- The tick is cleared by RST and restarts on accept.

Verification
REQ-032 CLK_DIV=4, DATA=10'h0AE, one-cycle start: bench SHALL check all of the following.
- DC=0 and bits 1,0,1,0,1,1,1,0 sampled on SCLK rising edges.
- WRITE_DONE at cycle +73.
- CS high again at +73.
REQ-033 DATA=10'h1FF: DC=1 during CS low and eight 1s; DATA=10'h100 gives eight 0s.
REQ-034 WRITE_START held high over 3 bytes: accepts spaced 74 cycles apart and exactly 3 WRITE_DONE pulses.
- Start pulses issued while BUSY produce nothing.
REQ-035 RST asserted at cycle +30 of a byte: outputs at reset values immediately and no WRITE_DONE.
- A new byte after release completes normally.
REQ-036 OLED_SPI_CS_HOLD_EN defined, DATA=10'h2A5 then 10'h0A5: CS stays low between the bytes and rises only after the second byte.
- Without the macro, CS rises after each byte.
REQ-037 CLK_DIV=1, DATA=10'h081: SCLK period is 2 CLK cycles and WRITE_DONE arrives at +19.
